// File: rtl/ex_stage.sv
// MIPS execute stage with EX/MEM pipeline register and an iterative unsigned
// multiply/divide unit that owns HI/LO and stalls dependent instructions.
module ex_stage #(
    parameter int MD_ITER = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ID_Valid,
    input  logic [ALUOP_W-1:0] ID_ALUOp,
    input  logic [2:0]         ID_MulDivOp,
    input  logic [31:0]        ID_OpA,
    input  logic [31:0]        ID_OpB,
    input  logic [31:0]        ID_WrData,
    input  logic               ID_RegWrite,
    input  logic               ID_MemRead,
    input  logic               ID_MemWrite,
    input  logic               ID_MemtoReg,
    input  logic [4:0]         ID_RegDest,
    input  logic               Flush,
    output logic               EX_RegWrite,
    output logic               EX_MemRead,
    output logic               EX_MemWrite,
    output logic               EX_MemtoReg,
    output logic [4:0]         EX_RegDest,
    output logic [31:0]        EX_ALUOut,
    output logic [31:0]        EX_WrData,
    output logic               EX_Stall
);

    localparam int CNT_W = $clog2(MD_ITER);

    if (MD_ITER != 32) begin : g_bad_iter
        $error("ex_stage: MD_ITER must be 32");
    end

    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_SRA  = ALUOP_W'(10);
    localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(11);

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIVU  = 3'd2;
    localparam logic [2:0] MD_MFHI  = 3'd3;
    localparam logic [2:0] MD_MFLO  = 3'd4;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [63:0]        acc_q, acc_d;
    logic [31:0]        opb_q;
    logic               div_q;
    logic [31:0]        hi_q, lo_q;

    logic [2:0]         md_op;
    logic               md_issue, md_any, md_start, load_bubble;
    logic signed [31:0] opa_s, opb_s;
    logic [4:0]         shamt;
    logic [31:0]        alu_res, ex_res;
    logic [32:0]        mul_sum, div_shift, div_sub;
    logic               div_ge;

    assign md_op    = (ID_MulDivOp > MD_MFLO) ? MD_NONE : ID_MulDivOp;
    assign md_issue = (md_op == MD_MULTU) || (md_op == MD_DIVU);
    assign md_any   = (md_op != MD_NONE);

    // Stall depends only on ID inputs and FSM state, never on EX_* outputs.
    assign EX_Stall    = ID_Valid & ~Flush & md_any & (state_q == BUSY);
    assign md_start    = ID_Valid & ~Flush & md_issue & ~EX_Stall & (state_q == IDLE);
    assign load_bubble = ~ID_Valid | Flush | EX_Stall | md_issue;

    assign opa_s = ID_OpA;
    assign opb_s = ID_OpB;
    assign shamt = ID_OpA[4:0];

    always_comb begin
        alu_res = '0;
        case (ID_ALUOp)
            ALU_ADD:  alu_res = ID_OpA + ID_OpB;
            ALU_SUB:  alu_res = ID_OpA - ID_OpB;
            ALU_AND:  alu_res = ID_OpA & ID_OpB;
            ALU_OR:   alu_res = ID_OpA | ID_OpB;
            ALU_XOR:  alu_res = ID_OpA ^ ID_OpB;
            ALU_NOR:  alu_res = ~(ID_OpA | ID_OpB);
            ALU_SLT:  alu_res = {31'd0, opa_s < opb_s};
            ALU_SLTU: alu_res = {31'd0, ID_OpA < ID_OpB};
            ALU_SLL:  alu_res = ID_OpB << shamt;
            ALU_SRL:  alu_res = ID_OpB >> shamt;
            ALU_SRA:  alu_res = opb_s >>> shamt;
            ALU_LUI:  alu_res = {ID_OpB[15:0], 16'h0000};
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        ex_res = alu_res;
        if (md_op == MD_MFHI) begin
            ex_res = hi_q;
        end else if (md_op == MD_MFLO) begin
            ex_res = lo_q;
        end
    end

    // acc holds {upper partial product, multiplier} for MULTU and
    // {partial remainder, dividend/quotient} for DIVU; both shift one bit per edge.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
        div_shift = {acc_q[63:32], acc_q[31]};
        div_sub   = div_shift - {1'b0, opb_q};
        div_ge    = (div_shift >= {1'b0, opb_q});
        acc_d     = {mul_sum, acc_q[31:1]};
        if (div_q) begin
            if (div_ge) begin
                acc_d = {div_sub[31:0], acc_q[30:0], 1'b1};
            end else begin
                acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (md_start) begin
                        state_q <= BUSY;
                        cnt_q   <= '0;
                        acc_q   <= {32'd0, ID_OpA};
                        opb_q   <= ID_OpB;
                        div_q   <= (md_op == MD_DIVU);
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    if (cnt_q == CNT_W'(MD_ITER - 1)) begin
                        hi_q    <= acc_d[63:32];
                        lo_q    <= acc_d[31:0];
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // EX/MEM pipeline register; bubbles are fully zeroed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            EX_RegWrite <= 1'b0;
            EX_MemRead  <= 1'b0;
            EX_MemWrite <= 1'b0;
            EX_MemtoReg <= 1'b0;
            EX_RegDest  <= '0;
            EX_ALUOut   <= '0;
            EX_WrData   <= '0;
        end else if (load_bubble) begin
            EX_RegWrite <= 1'b0;
            EX_MemRead  <= 1'b0;
            EX_MemWrite <= 1'b0;
            EX_MemtoReg <= 1'b0;
            EX_RegDest  <= '0;
            EX_ALUOut   <= '0;
            EX_WrData   <= '0;
        end else begin
            EX_RegWrite <= ID_RegWrite;
            EX_MemRead  <= ID_MemRead;
            EX_MemWrite <= ID_MemWrite;
            EX_MemtoReg <= ID_MemtoReg;
            EX_RegDest  <= ID_RegDest;
            EX_ALUOut   <= ex_res;
            EX_WrData   <= ID_WrData;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a behavioural model predicts stall and the
// EX/MEM contents for every cycle; predictions are queued and popped after the edge.
module tb_ex_stage;
    localparam int MD_ITER = 32;
    localparam int ALUOP_W = 4;

    logic               clk;
    logic               reset;
    logic               ID_Valid;
    logic [ALUOP_W-1:0] ID_ALUOp;
    logic [2:0]         ID_MulDivOp;
    logic [31:0]        ID_OpA, ID_OpB, ID_WrData;
    logic               ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg;
    logic [4:0]         ID_RegDest;
    logic               Flush;
    logic               EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg;
    logic [4:0]         EX_RegDest;
    logic [31:0]        EX_ALUOut, EX_WrData;
    logic               EX_Stall;

    ex_stage #(.MD_ITER(MD_ITER), .ALUOP_W(ALUOP_W)) dut (
        .clk(clk), .reset(reset),
        .ID_Valid(ID_Valid), .ID_ALUOp(ID_ALUOp), .ID_MulDivOp(ID_MulDivOp),
        .ID_OpA(ID_OpA), .ID_OpB(ID_OpB), .ID_WrData(ID_WrData),
        .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
        .ID_MemWrite(ID_MemWrite), .ID_MemtoReg(ID_MemtoReg),
        .ID_RegDest(ID_RegDest), .Flush(Flush),
        .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead),
        .EX_MemWrite(EX_MemWrite), .EX_MemtoReg(EX_MemtoReg),
        .EX_RegDest(EX_RegDest), .EX_ALUOut(EX_ALUOut), .EX_WrData(EX_WrData),
        .EX_Stall(EX_Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [72:0] rec_t;
    rec_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          stall_cnt = 0;
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;

    task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = ~(a | b);
            4'd6:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  r = (a < b) ? 32'd1 : 32'd0;
            4'd8:  r = b << a[4:0];
            4'd9:  r = b >> a[4:0];
            4'd10: r = sb >>> a[4:0];
            4'd11: r = {b[15:0], 16'h0000};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic rec_t ex_rec();
        return {EX_RegWrite, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_RegDest, EX_ALUOut, EX_WrData};
    endfunction

    task automatic drv(input logic v, input logic [3:0] aop, input logic [2:0] mop,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] wd,
                       input logic [3:0] ctl, input logic [4:0] rd, input logic fl);
        ID_Valid    = v;
        ID_ALUOp    = aop;
        ID_MulDivOp = mop;
        ID_OpA      = a;
        ID_OpB      = b;
        ID_WrData   = wd;
        {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg} = ctl;
        ID_RegDest  = rd;
        Flush       = fl;
    endtask

    task automatic nop();
        drv(1'b0, 4'd0, 3'd0, 32'd0, 32'd0, 32'd0, 4'd0, 5'd0, 1'b0);
    endtask

    // One clock: predict stall and EX contents, advance the model, then compare.
    task automatic step(input string tag);
        logic [2:0]  op;
        logic        stall, bubble, start;
        logic [31:0] res;
        rec_t        e;
        op = (ID_MulDivOp > 3'd4) ? 3'd0 : ID_MulDivOp;
        @(negedge clk);
        stall = ID_Valid & ~Flush & (op != 3'd0) & m_busy;
        check({tag, "/stall"}, {72'd0, EX_Stall}, {72'd0, stall});
        if (EX_Stall) stall_cnt++;
        bubble = ~ID_Valid | Flush | stall | (op == 3'd1) | (op == 3'd2);
        res = (op == 3'd3) ? m_hi : (op == 3'd4) ? m_lo : alu_ref(ID_ALUOp, ID_OpA, ID_OpB);
        e = bubble ? '0 : {ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegDest, res, ID_WrData};
        exp_q.push_back(e);
        start = ID_Valid & ~Flush & ((op == 3'd1) | (op == 3'd2)) & ~stall;
        if (m_busy) begin
            m_cnt++;
            if (m_cnt == MD_ITER) begin
                m_busy = 1'b0;
                m_hi   = m_phi;
                m_lo   = m_plo;
            end
        end else if (start) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            if (op == 3'd1) begin
                {m_phi, m_plo} = {32'd0, ID_OpA} * {32'd0, ID_OpB};
            end else if (ID_OpB == 32'd0) begin
                m_plo = 32'hFFFF_FFFF;
                m_phi = ID_OpA;
            end else begin
                m_plo = ID_OpA / ID_OpB;
                m_phi = ID_OpA % ID_OpB;
            end
        end
        @(posedge clk);
        #1;
        check(tag, ex_rec(), exp_q.pop_front());
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1 check(tag, ex_rec(), '0);
        m_busy = 1'b0;
        m_cnt  = 0;
        m_hi   = '0;
        m_lo   = '0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        nop();
        #12;
        check("reset_outputs", ex_rec(), '0);
        check("reset_stall", {72'd0, EX_Stall}, 73'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ALU sweep: {valid, aluop, mdop, A, B, wdata, ctl, rd, flush}
        drv(1, 4'd0,  3'd0, 32'h7FFF_FFFF, 32'h1,         32'h11, 4'b1000, 5'd3, 0); step("add_ovf");
        drv(1, 4'd1,  3'd0, 32'h0,         32'h1,         32'h22, 4'b1000, 5'd4, 0); step("sub_wrap");
        drv(1, 4'd2,  3'd0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h0,  4'b1000, 5'd5, 0); step("and");
        drv(1, 4'd3,  3'd0, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0,  4'b1000, 5'd6, 0); step("or");
        drv(1, 4'd4,  3'd0, 32'hAAAA_5555, 32'hFFFF_0000, 32'h0,  4'b1000, 5'd7, 0); step("xor");
        drv(1, 4'd5,  3'd0, 32'h0000_00FF, 32'h0F00_0000, 32'h0,  4'b1000, 5'd8, 0); step("nor");
        drv(1, 4'd6,  3'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,  4'b1000, 5'd9, 0); step("slt");
        check("slt_val", {41'd0, EX_ALUOut}, 73'd1);
        drv(1, 4'd7,  3'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,  4'b1000, 5'd9, 0); step("sltu");
        check("sltu_val", {41'd0, EX_ALUOut}, 73'd0);
        drv(1, 4'd8,  3'd0, 32'd31,        32'h3,         32'h0,  4'b1000, 5'd10, 0); step("sll");
        drv(1, 4'd9,  3'd0, 32'd4,         32'h8000_0000, 32'h0,  4'b1000, 5'd11, 0); step("srl");
        drv(1, 4'd10, 3'd0, 32'd4,         32'h8000_0000, 32'h0,  4'b1000, 5'd12, 0); step("sra");
        check("sra_val", {41'd0, EX_ALUOut}, {41'd0, 32'hF800_0000});
        drv(1, 4'd13, 3'd0, 32'h5,         32'h6,         32'h0,  4'b1000, 5'd13, 0); step("op13_zero");
        drv(1, 4'd0,  3'd6, 32'h5,         32'h6,         32'h0,  4'b1000, 5'd14, 0); step("mdop6_as_alu");
        drv(1, 4'd0,  3'd0, 32'h2000,      32'h8,    32'hCAFE_F00D,  4'b0010, 5'd0, 0); step("store");
        drv(0, 4'd0,  3'd0, 32'h1,         32'h1,         32'h1,  4'b1111, 5'd1, 0); step("invalid");
        drv(1, 4'd11, 3'd0, 32'h0,         32'h1234,      32'h0,  4'b1000, 5'd15, 0); step("lui");
        check("lui_val", {41'd0, EX_ALUOut}, {41'd0, 32'h1234_0000});

        async_reset("async_reset");
        drv(1, 4'd0, 3'd3, 32'h0, 32'h0, 32'h0, 4'b1000, 5'd2, 0); step("mfhi_after_reset");

        // MULTU 0xFFFFFFFF * 2 with dependent MFHI held until it issues
        drv(1, 4'd0, 3'd1, 32'hFFFF_FFFF, 32'h2, 32'h0, 4'b1000, 5'd1, 0); step("multu_issue");
        check("multu_regwrite", {72'd0, EX_RegWrite}, 73'd0);
        stall_cnt = 0;
        drv(1, 4'd0, 3'd3, 32'h0, 32'h0, 32'h0, 4'b1000, 5'd2, 0);
        for (int i = 0; i < 33; i++) step("mfhi_wait");
        check("mul_stall_cycles", 73'(stall_cnt), 73'd32);
        check("mfhi_mul", {41'd0, EX_ALUOut}, {41'd0, 32'h0000_0001});
        drv(1, 4'd0, 3'd4, 32'h0, 32'h0, 32'h0, 4'b1000, 5'd3, 0); step("mflo_mul");
        check("mflo_mul_val", {41'd0, EX_ALUOut}, {41'd0, 32'hFFFF_FFFE});

        // DIVU 100/7 and 5/0
        drv(1, 4'd0, 3'd2, 32'd100, 32'd7, 32'h0, 4'b1000, 5'd1, 0); step("divu_issue");
        drv(1, 4'd0, 3'd4, 32'h0, 32'h0, 32'h0, 4'b1000, 5'd4, 0);
        for (int i = 0; i < 33; i++) step("mflo_div_wait");
        check("divu_lo", {41'd0, EX_ALUOut}, 73'd14);
        drv(1, 4'd0, 3'd3, 32'h0, 32'h0, 32'h0, 4'b1000, 5'd5, 0); step("mfhi_div");
        check("divu_hi", {41'd0, EX_ALUOut}, 73'd2);
        drv(1, 4'd0, 3'd2, 32'd5, 32'd0, 32'h0, 4'b1000, 5'd1, 0); step("div0_issue");
        drv(1, 4'd0, 3'd4, 32'h0, 32'h0, 32'h0, 4'b1000, 5'd4, 0);
        for (int i = 0; i < 33; i++) step("div0_wait");
        check("div0_lo", {41'd0, EX_ALUOut}, {41'd0, 32'hFFFF_FFFF});
        drv(1, 4'd0, 3'd3, 32'h0, 32'h0, 32'h0, 4'b1000, 5'd5, 0); step("div0_mfhi");
        check("div0_hi", {41'd0, EX_ALUOut}, 73'd5);

        // Load proceeds while BUSY; flushed MFHI is a bubble without stall
        drv(1, 4'd0, 3'd1, 32'd3, 32'd5, 32'h0, 4'b1000, 5'd1, 0); step("mul15_issue");
        drv(1, 4'd0, 3'd0, 32'h1000_0000, 32'h4, 32'h0, 4'b1101, 5'd8, 0); step("load_busy");
        check("load_addr", {41'd0, EX_ALUOut}, {41'd0, 32'h1000_0004});
        check("load_memread", {72'd0, EX_MemRead}, 73'd1);
        drv(1, 4'd0, 3'd3, 32'h0, 32'h0, 32'h0, 4'b1000, 5'd2, 1); step("flush_stalled_mfhi");
        nop();
        for (int i = 0; i < 32; i++) step("drain");
        drv(1, 4'd0, 3'd4, 32'h0, 32'h0, 32'h0, 4'b1000, 5'd3, 0); step("mflo15");
        check("mflo15_val", {41'd0, EX_ALUOut}, 73'd15);

        // Flushed MULTU never starts: MFLO is immediate and unchanged
        drv(1, 4'd0, 3'd1, 32'd7, 32'd7, 32'h0, 4'b1000, 5'd1, 1); step("flush_multu");
        drv(1, 4'd0, 3'd4, 32'h0, 32'h0, 32'h0, 4'b1000, 5'd3, 0); step("mflo_after_flush");
        check("flush_multu_lo", {41'd0, EX_ALUOut}, 73'd15);

        // Reset ten cycles into a DIVU clears HI/LO and aborts it
        drv(1, 4'd0, 3'd2, 32'd1000, 32'd3, 32'h0, 4'b1000, 5'd1, 0); step("divu_abort_issue");
        nop();
        for (int i = 0; i < 10; i++) step("divu_abort_run");
        async_reset("reset_mid_div");
        drv(1, 4'd0, 3'd3, 32'h0, 32'h0, 32'h0, 4'b1000, 5'd2, 0); step("mfhi_post_abort");
        drv(1, 4'd0, 3'd4, 32'h0, 32'h0, 32'h0, 4'b1000, 5'd3, 0); step("mflo_post_abort");
        check("post_abort_lo", {41'd0, EX_ALUOut}, 73'd0);

        nop();
        step("final_nop");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
